// File: rtl/render_ctrl_pkg.sv
// Shared types and widths for the render-domain frame control logic.
// No logic of its own: enum, struct and width constants only.
// Not applicable (no handshake).
package render_ctrl_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SWAP,
        CLEAR,
        START,
        RENDER,
        DONE
    } sched_state_t;

    // Framebuffer write-port coordinate widths
    localparam int FB_X_W = 8;
    localparam int FB_Y_W = 7;

    // 12-bit colour, red in the top nibble
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/fb_clear_walker.sv
// Raster-scan x/y pixel counter used to sweep the back buffer, x fastest.
// Position updates one cycle after advance; start returns to (0,0) next cycle.
// No backpressure: advances unconditionally whenever advance is high.
module fb_clear_walker #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    localparam int XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1,
    localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_LAST = XW'(FB_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FB_HEIGHT - 1);

    // Step through the frame, wrapping x into a y increment at the row end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (start) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Flag the final pixel of the frame
    always_comb begin
        last = (x == X_LAST) && (y == Y_LAST);
    end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: swap, optional back-buffer clear, feeder launch, drain wait.
// Framebuffer write port is registered: 1 cycle from raster_* or the clear walker.
// Rasterizer is stalled (raster_out_ready=0) while swapping/clearing; the walker owns the port.
module frame_scheduler
    import render_ctrl_pkg::*;
#(
    parameter int FB_WIDTH          = 160,
    parameter int FB_HEIGHT         = 120,
    parameter int MIN_RENDER_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              clear_en,
    input  logic [11:0]       clear_color,
    output logic              swap,
    output logic              begin_frame,
    input  logic              feeder_busy,
    input  logic              raster_busy,
    input  logic              raster_we,
    input  logic [7:0]        raster_x,
    input  logic [6:0]        raster_y,
    input  logic [11:0]       raster_color,
    output logic              raster_out_ready,
    output logic              fb_we,
    output logic [FB_X_W-1:0] fb_x,
    output logic [FB_Y_W-1:0] fb_y,
    output logic [11:0]       fb_data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic [15:0]       overrun_count
);

    localparam int XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
    localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
    localparam int GW = (MIN_RENDER_CYCLES > 0) ? $clog2(MIN_RENDER_CYCLES + 1) : 1;

    sched_state_t  state, state_nxt;
    rgb444_t       clr_color;
    logic [GW-1:0] guard;
    logic [XW-1:0] walk_x;
    logic [YW-1:0] walk_y;
    logic          walk_last;
    logic          pipe_idle;

    fb_clear_walker #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_walker (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (state == SWAP),
        .advance (state == CLEAR),
        .x       (walk_x),
        .y       (walk_y),
        .last    (walk_last)
    );

    // Pipeline is only trusted idle once the feeder has had time to raise busy
    assign pipe_idle = (guard == '0) && !feeder_busy && !raster_busy && !raster_we;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: clear is decided by clear_en as seen during SWAP
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = SWAP;
            SWAP:    state_nxt = clear_en ? CLEAR : START;
            CLEAR:   if (walk_last) state_nxt = START;
            START:   state_nxt = RENDER;
            RENDER:  if (pipe_idle) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register, so each pulse lasts one state
    always_comb begin
        swap             = (state == SWAP);
        begin_frame      = (state == START);
        frame_done       = (state == DONE);
        busy             = (state != IDLE);
        raster_out_ready = (state != SWAP) && (state != CLEAR);
    end

    // Clear colour snapshot and render guard counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_color <= '0;
            guard     <= '0;
        end else begin
            if (state == SWAP)
                clr_color <= rgb444_t'(clear_color);
            if (state == START)
                guard <= GW'(MIN_RENDER_CYCLES);
            else if (state == RENDER && guard != '0)
                guard <= guard - 1'b1;
        end
    end

    // Write-port mux: walker during CLEAR, nothing during SWAP, rasterizer otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we   <= 1'b0;
            fb_x    <= '0;
            fb_y    <= '0;
            fb_data <= '0;
        end else begin
            case (state)
                SWAP: begin
                    fb_we   <= 1'b0;
                    fb_x    <= '0;
                    fb_y    <= '0;
                    fb_data <= '0;
                end
                CLEAR: begin
                    fb_we   <= 1'b1;
                    fb_x    <= FB_X_W'(walk_x);
                    fb_y    <= FB_Y_W'(walk_y);
                    fb_data <= clr_color;
                end
                default: begin
                    fb_we   <= raster_we;
                    fb_x    <= raster_x;
                    fb_y    <= raster_y;
                    fb_data <= raster_color;
                end
            endcase
        end
    end

    // Completed-frame (wrapping) and rejected-start (saturating) counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            if (state == DONE)
                frame_count <= frame_count + 16'd1;
            if (frame_start && state != IDLE && overrun_count != 16'hFFFF)
                overrun_count <= overrun_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler on a 4x3 framebuffer with a write scoreboard.
// Framebuffer writes are checked in order against an expected-write queue.
// Cycle offsets k are relative to the cycle in which frame_start is driven.
module tb_frame_scheduler;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int MIN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start, clear_en, feeder_busy, raster_busy, raster_we;
    logic [11:0] clear_color, raster_color;
    logic [7:0]  raster_x;
    logic [6:0]  raster_y;
    logic        swap, begin_frame, raster_out_ready, fb_we, busy, frame_done;
    logic [7:0]  fb_x;
    logic [6:0]  fb_y;
    logic [11:0] fb_data;
    logic [15:0] frame_count, overrun_count;

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [11:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    frame_scheduler #(
        .FB_WIDTH          (W),
        .FB_HEIGHT         (H),
        .MIN_RENDER_CYCLES (MIN)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .clear_en         (clear_en),
        .clear_color      (clear_color),
        .swap             (swap),
        .begin_frame      (begin_frame),
        .feeder_busy      (feeder_busy),
        .raster_busy      (raster_busy),
        .raster_we        (raster_we),
        .raster_x         (raster_x),
        .raster_y         (raster_y),
        .raster_color     (raster_color),
        .raster_out_ready (raster_out_ready),
        .fb_we            (fb_we),
        .fb_x             (fb_x),
        .fb_y             (fb_y),
        .fb_data          (fb_data),
        .busy             (busy),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .overrun_count    (overrun_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear(input logic [11:0] color);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                exp_q.push_back('{x: 8'(xx), y: 7'(yy), d: color});
    endtask

    // Scoreboard: every framebuffer write must match the oldest expected write
    always begin
        wr_t got, e;
        @(posedge clk);
        #2;
        if (rst_n && fb_we) begin
            got = '{x: fb_x, y: fb_y, d: fb_data};
            if (exp_q.size() == 0) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_write: observed x=%0d y=%0d d=0x%0h expected no write",
                           fb_x, fb_y, fb_data);
                end
            end else begin
                e = exp_q.pop_front();
                chk("fb_write", 32'(got), 32'(e));
            end
        end
    end

    initial begin
        int n;
        frame_start  = 0; clear_en = 0; clear_color = 0;
        feeder_busy  = 0; raster_busy = 0; raster_we = 0;
        raster_x     = 0; raster_y = 0; raster_color = 0;

        // Reset state
        #12;
        chk("rst_swap", swap, 0);
        chk("rst_begin", begin_frame, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", raster_out_ready, 1);
        chk("rst_fb", {fb_we, fb_x, fb_y, fb_data}, 0);
        chk("rst_fcount", frame_count, 0);
        chk("rst_ocount", overrun_count, 0);
        step(); step();
        rst_n = 1;
        step();

        // Clear frame: 0x0F0 on 4x3, inputs changed after SWAP to prove latching
        clear_en = 1; clear_color = 12'h0F0; push_clear(12'h0F0); frame_start = 1;
        for (int k = 1; k <= 19; k++) begin
            step();
            frame_start = 0;
            if (k >= 2) begin clear_en = 0; clear_color = 12'h123; end
            chk("clr_swap", swap, (k == 1));
            chk("clr_begin", begin_frame, (k == 14));
            chk("clr_done", frame_done, (k == 18));
            if (k <= 14) begin
                chk("clr_ready", raster_out_ready, (k == 14));
                chk("clr_we", fb_we, (k >= 3));
                chk("clr_busy", busy, 1);
            end
        end
        chk("clr_fcount", frame_count, 1);
        chk("clr_idle", busy, 0);
        chk("clr_q_empty", exp_q.size(), 0);

        // No clear, feeder held busy, rasterizer passthrough, overruns incl. DONE cycle
        step();
        clear_en = 0; frame_start = 1;
        for (int k = 1; k <= 54; k++) begin
            step();
            frame_start = (k == 10 || k == 15 || k == 30 || k == 52);
            feeder_busy = (k >= 3 && k <= 50);
            raster_we   = (k == 20);
            if (k == 20) begin
                raster_x = 8'd5; raster_y = 7'd7; raster_color = 12'hABC;
                exp_q.push_back('{x: 8'd5, y: 7'd7, d: 12'hABC});
            end else begin
                raster_x = 0; raster_y = 0; raster_color = 0;
            end
            chk("nc_swap", swap, (k == 1));
            chk("nc_begin", begin_frame, (k == 2));
            chk("nc_done", frame_done, (k == 52));
            if (k == 21) chk("nc_passthru", {fb_we, fb_x, fb_y, fb_data}, {1'b1, 8'd5, 7'd7, 12'hABC});
            if (k == 53) begin
                chk("nc_fcount", frame_count, 2);
                chk("nc_idle", busy, 0);
                chk("nc_ocount", overrun_count, 4);
            end
        end
        frame_start = 0;
        chk("nc_q_empty", exp_q.size(), 0);

        // Reset during the sixth clear write
        step();
        clear_en = 1; clear_color = 12'h5A5; push_clear(12'h5A5); frame_start = 1;
        for (int k = 1; k <= 8; k++) begin
            step();
            frame_start = 0;
            if (k >= 2) clear_en = 0;
        end
        chk("mid_6th_we", fb_we, 1);
        chk("mid_6th_pos", {fb_x, fb_y}, {8'd1, 7'd1});
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_fb", {fb_we, fb_x, fb_y, fb_data}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pulses", {swap, begin_frame, frame_done}, 0);
        chk("mid_rst_ready", raster_out_ready, 1);
        chk("mid_rst_counts", {frame_count, overrun_count}, 0);
        exp_q.delete();
        step(); step();
        rst_n = 1;
        step();

        // Restart after reset: clear begins again at (0,0)
        clear_en = 1; clear_color = 12'h00F; push_clear(12'h00F); frame_start = 1;
        for (int k = 1; k <= 19; k++) begin
            step();
            frame_start = 0;
            if (k >= 2) clear_en = 0;
            if (k == 3) chk("rs_first_pos", {fb_we, fb_x, fb_y}, {1'b1, 8'd0, 7'd0});
            chk("rs_begin", begin_frame, (k == 14));
            chk("rs_done", frame_done, (k == 18));
        end
        chk("rs_fcount", frame_count, 1);
        chk("rs_q_empty", exp_q.size(), 0);

        // Saturation: frame_start held high through a long RENDER
        step();
        clear_en = 0; feeder_busy = 1; frame_start = 1;
        for (int i = 0; i < 65540; i++) step();
        chk("sat_ocount", overrun_count, 16'hFFFF);
        frame_start = 0; feeder_busy = 0;
        n = 0;
        while (!frame_done && n < 20) begin step(); n++; end
        chk("sat_frame_done", frame_done, 1);
        step(); step();
        chk("sat_ocount_hold", overrun_count, 16'hFFFF);
        chk("sat_fcount", frame_count, 2);
        chk("sat_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
